// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D cache line memory arbiter.
//   - default widths and starvation limit used as parameter defaults
//   - arbiter FSM state encoding
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF     = 28;
  localparam int LINE_W_DEF     = 128;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one memory port.
// D has priority, but after STARVE_MAX consecutive D grants with I waiting,
// I is granted. Each transaction runs IDLE -> SERVE_x -> DONE -> IDLE.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   i_read/i_write/i_addr/i_wdata I-cache request (write wins if both set)
//   i_ready/i_rdata               I completion pulse and read data
//   d_read/d_write/d_addr/d_wdata D-cache request (write wins if both set)
//   d_ready/d_rdata               D completion pulse and read data
//   mem_read/mem_write/mem_addr/mem_wdata  registered memory command
//   mem_ready/mem_rdata           memory completion pulse and read data
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LINE_W     = LINE_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              i_ready,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   starve_cnt;
  logic               starve_full;
  logic               i_pend, d_pend;
  logic               grant_i, grant_d;
  logic [LINE_W-1:0]  i_rdata_q, d_rdata_q;

  assign i_pend      = i_read | i_write;
  assign d_pend      = d_read | d_write;
  assign starve_full = (starve_cnt == CNT_W'(STARVE_MAX));

  // Read data is passed straight through in the ready cycle and held after.
  assign i_rdata = i_ready ? mem_rdata : i_rdata_q;
  assign d_rdata = d_ready ? mem_rdata : d_rdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    unique case (state)
      IDLE: begin
        // D wins ties unless I has been passed over STARVE_MAX times.
        if (d_pend && !(i_pend && starve_full)) begin
          grant_d   = 1'b1;
          state_nxt = SERVE_D;
        end else if (i_pend) begin
          grant_i   = 1'b1;
          state_nxt = SERVE_I;
        end
      end
      SERVE_I: begin
        if (mem_ready) begin
          i_ready   = 1'b1;
          state_nxt = DONE;
        end
      end
      SERVE_D: begin
        if (mem_ready) begin
          d_ready   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory command, starvation counter and read-data hold registers.
  // NOTE: the read-data hold registers are reset too, because the reset
  // value of i_rdata/d_rdata is architecturally visible (zero).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      starve_cnt <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (grant_i) begin
        mem_addr   <= i_addr;
        mem_wdata  <= i_wdata;
        mem_write  <= i_write;
        mem_read   <= i_read & ~i_write;
        starve_cnt <= '0;
      end else if (grant_d) begin
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_write <= d_write;
        mem_read  <= d_read & ~d_write;
        if (i_pend && !starve_full) starve_cnt <= starve_cnt + CNT_W'(1);
      end else if (i_ready || d_ready) begin
        // Strobes drop entering DONE; address/data are left as they were.
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
      if (i_ready) i_rdata_q <= mem_rdata;
      if (d_ready) d_rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a memory responder model, a
// scoreboard of expected memory commands in grant order, and a monitor that
// pops and compares on each new memory command and on each ready pulse.
module tb_mem_arbiter;

  typedef struct {
    bit           port;   // 0 = I, 1 = D
    bit           rd;
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         i_read, i_write, d_read, d_write;
  logic [27:0]  i_addr, d_addr;
  logic [127:0] i_wdata, d_wdata;
  logic         i_ready, d_ready;
  logic [127:0] i_rdata, d_rdata;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;

  logic resp_ready, stray_ready;
  assign mem_ready = resp_ready | stray_ready;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   lat   = 3;
  int   scnt  = 0;
  exp_t exp_q[$];

  mem_arbiter #(.ADDR_W(28), .LINE_W(128), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_ready(i_ready), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] rdata_of(input logic [27:0] a);
    if (a == 28'h0000010) return {16{8'hA5}};
    return {4{4'h5, a}};
  endfunction

  task automatic push_exp(input bit port, input bit rd, input bit wr,
                          input logic [27:0] addr, input logic [127:0] wd);
    exp_t e;
    e.port  = port;
    e.wr    = wr;
    e.rd    = rd & ~wr;
    e.addr  = addr;
    e.wdata = wd;
    e.rdata = rdata_of(addr);
    exp_q.push_back(e);
  endtask

  task automatic set_i(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] wd);
    i_read = rd; i_write = wr; i_addr = a; i_wdata = wd;
  endtask

  task automatic set_d(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] wd);
    d_read = rd; d_write = wr; d_addr = a; d_wdata = wd;
  endtask

  // Returns in the ready cycle (after the negedge); bounded wait.
  task automatic wait_rdy(input bit port);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      #3;
      seen = port ? d_ready : i_ready;
    end
    if (!seen) check(port ? "d_timeout" : "i_timeout", 128'(0), 128'(1));
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_mem_read"},  128'(mem_read),  128'(0));
    check({pfx, "_mem_write"}, 128'(mem_write), 128'(0));
    check({pfx, "_mem_addr"},  128'(mem_addr),  128'(0));
    check({pfx, "_mem_wdata"}, mem_wdata,       128'(0));
    check({pfx, "_i_ready"},   128'(i_ready),   128'(0));
    check({pfx, "_d_ready"},   128'(d_ready),   128'(0));
    check({pfx, "_i_rdata"},   i_rdata,         128'(0));
    check({pfx, "_d_rdata"},   d_rdata,         128'(0));
  endtask

  // Memory model: ready after 'lat' strobe cycles, one-cycle pulse.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      resp_ready = 1'b0;
      scnt       = 0;
    end else if (resp_ready) begin
      resp_ready = 1'b0;
    end else if (mem_read | mem_write) begin
      scnt++;
      if (scnt >= lat) begin
        resp_ready = 1'b1;
        mem_rdata  = rdata_of(mem_addr);
        scnt       = 0;
      end
    end else begin
      scnt = 0;
    end
  end

  // Monitor / scoreboard.
  exp_t         cur;
  bit           inflight = 1'b0;
  bit           prev_strobe = 1'b0;
  int           slen = 0, last_len = 0, rise_cyc = 0, ready_cyc = 0;
  logic [127:0] last_i = '0, last_d = '0;

  always @(negedge clk) begin
    bit strobe;
    #2;
    if (rst) begin
      inflight    = 1'b0;
      prev_strobe = 1'b0;
      slen        = 0;
      last_i      = '0;
      last_d      = '0;
    end else begin
      strobe = mem_read | mem_write;
      if (strobe && !prev_strobe) begin
        rise_cyc = cyc;
        slen     = 1;
        if (exp_q.size() == 0) begin
          check("grant_unexpected", 128'(1), 128'(0));
        end else begin
          cur      = exp_q.pop_front();
          inflight = 1'b1;
          check("cmd_read",  128'(mem_read),  128'(cur.rd));
          check("cmd_write", 128'(mem_write), 128'(cur.wr));
          check("cmd_addr",  128'(mem_addr),  128'(cur.addr));
          check("cmd_wdata", mem_wdata,       cur.wdata);
        end
      end else if (strobe) begin
        slen++;
        if (inflight)
          check("cmd_hold", {mem_wdata[95:0], mem_addr, 2'b00, mem_read, mem_write},
                {cur.wdata[95:0], cur.addr, 2'b00, cur.rd, cur.wr});
      end else if (prev_strobe) begin
        last_len = slen;
      end
      if (i_ready || d_ready) begin
        ready_cyc = cyc;
        check("rdy_both",     128'(i_ready & d_ready), 128'(0));
        check("rdy_inflight", 128'(inflight), 128'(1));
        check("rdy_port",     128'(d_ready),  128'(cur.port));
        if (d_ready) begin
          check("d_rdata",      d_rdata, cur.rdata);
          check("i_rdata_hold", i_rdata, last_i);
          last_d = d_rdata;
        end else begin
          check("i_rdata",      i_rdata, cur.rdata);
          check("d_rdata_hold", d_rdata, last_d);
          last_i = i_rdata;
        end
        inflight = 1'b0;
      end
      prev_strobe = strobe;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cyc;
    rst = 1'b1;
    stray_ready = 1'b0;
    resp_ready  = 1'b0;
    mem_rdata   = '0;
    set_i(0, 0, '0, '0);
    set_d(0, 0, '0, '0);

    // Reset values.
    repeat (2) @(negedge clk);
    #3 check_all_zero("reset");
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    // I-only read, ready on 3rd SERVE cycle.
    lat = 3;
    push_exp(0, 1, 0, 28'h0000010, '0);
    set_i(1, 0, 28'h0000010, '0);
    req_cyc = cyc;
    wait_rdy(0);
    i_read = 1'b0;
    @(negedge clk);                // DONE cycle: stray mem_ready
    stray_ready = 1'b1;
    #3;
    check("strobe_len",     128'(last_len), 128'(3));
    check("lat_grant",      128'(rise_cyc - req_cyc), 128'(1));
    check("lat_ready",      128'(ready_cyc - rise_cyc), 128'(2));
    check("i_rdata_a5",     i_rdata, {16{8'hA5}});
    check("done_stray_i",   128'(i_ready), 128'(0));
    check("done_strobe",    128'(mem_read | mem_write), 128'(0));
    @(negedge clk);                // IDLE cycle: stray mem_ready
    #3;
    check("idle_stray_rdy", 128'(i_ready | d_ready), 128'(0));
    @(negedge clk) stray_ready = 1'b0;
    #3 check("idle_stray_nogrant", 128'(mem_read | mem_write), 128'(0));

    // D read+write together is a write.
    lat = 2;
    @(negedge clk);
    push_exp(1, 1, 1, 28'h0ABCDEF, {4{32'hDEADBEEF}});
    set_d(1, 1, 28'h0ABCDEF, {4{32'hDEADBEEF}});
    wait_rdy(1);
    set_d(0, 0, '0, '0);

    // Both pending, starve_cnt 0: D first, then I.
    @(negedge clk);
    push_exp(1, 1, 0, 28'h0000200, '0);
    push_exp(0, 0, 1, 28'h0000100, {4{32'h11112222}});
    fork
      begin set_i(0, 1, 28'h0000100, {4{32'h11112222}}); wait_rdy(0); set_i(0, 0, '0, '0); end
      begin set_d(1, 0, 28'h0000200, '0); wait_rdy(1); set_d(0, 0, '0, '0); end
    join

    // Starvation: D continuous, I pending -> 4 D grants, then I, then last D.
    lat = 1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) push_exp(1, 1, 0, 28'h0000300 + 28'(k), '0);
    push_exp(0, 1, 0, 28'h0000180, '0);
    push_exp(1, 1, 0, 28'h0000304, '0);
    fork
      begin set_i(1, 0, 28'h0000180, '0); wait_rdy(0); set_i(0, 0, '0, '0); end
      begin
        for (int k = 0; k < 5; k++) begin
          set_d(1, 0, 28'h0000300 + 28'(k), '0);
          wait_rdy(1);
        end
        set_d(0, 0, '0, '0);
      end
    join

    // Counter must be cleared: tie goes to D again.
    lat = 2;
    @(negedge clk);
    push_exp(1, 0, 1, 28'h0000220, {4{32'h33334444}});
    push_exp(0, 1, 0, 28'h0000120, '0);
    fork
      begin set_i(1, 0, 28'h0000120, '0); wait_rdy(0); set_i(0, 0, '0, '0); end
      begin set_d(0, 1, 28'h0000220, {4{32'h33334444}}); wait_rdy(1); set_d(0, 0, '0, '0); end
    join

    // Reset mid SERVE_D: abort, then re-arbitrate the held request.
    lat = 6;
    @(negedge clk);
    push_exp(1, 1, 0, 28'h0000400, '0);
    push_exp(1, 1, 0, 28'h0000400, '0);
    fork
      begin set_d(1, 0, 28'h0000400, '0); wait_rdy(1); set_d(0, 0, '0, '0); end
      begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #3 check_all_zero("midrst");
        @(negedge clk) rst = 1'b0;
        #3 check("rearb_idle", 128'(mem_read), 128'(0));
        @(negedge clk);
        #3 check("rearb_rise", 128'(mem_read), 128'(1));
      end
    join

    repeat (3) @(negedge clk);
    #3 check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
